// File: rtl/anon_struct_skid.sv
// Two-entry registered skid buffer carrying an anonymous packed {seq, tag, data} payload.
// Optional macro ANON_STRUCT_SKID_PARITY_EN appends an even-parity bit and the out_parity port.
module anon_struct_skid #(
  parameter int unsigned          DATA_W     = 4,
  parameter int unsigned          TAG_W      = 2,
  parameter int unsigned          SEQ_W      = 3,
  parameter logic [DATA_W-1:0]    RESET_DATA = DATA_W'(4'h5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [SEQ_W-1:0]  out_seq
`ifdef ANON_STRUCT_SKID_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, next_state;

  struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
`ifdef ANON_STRUCT_SKID_PARITY_EN
    logic              parity;
`endif
  } in_pl, reset_pl, head_q, skid_q;

  logic [SEQ_W-1:0] seq_cnt;
  logic             accept;
  logic             pop;
  logic             load_head_in;
  logic             load_head_skid;
  logic             load_skid;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);

  // The accepted payload is stamped with the running sequence number.
  always_comb begin
    in_pl          = '0;
    in_pl.seq      = seq_cnt;
    in_pl.tag      = in_tag;
    in_pl.data     = in_data;
    reset_pl       = '0;
    reset_pl.data  = RESET_DATA;
`ifdef ANON_STRUCT_SKID_PARITY_EN
    in_pl.parity    = ^{seq_cnt, in_tag, in_data};
    reset_pl.parity = ^RESET_DATA;
`endif
  end

  always_comb begin
    next_state     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_head_in = 1'b1;
          next_state   = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_head_skid = 1'b1;
          next_state     = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // in_ready is its own flop so it reads low for the whole reset window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      seq_cnt  <= '0;
      head_q   <= reset_pl;
      skid_q   <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
      if (accept)
        seq_cnt <= seq_cnt + SEQ_W'(1);
      if (load_head_in)
        head_q <= in_pl;
      else if (load_head_skid)
        head_q <= skid_q;
      if (load_skid)
        skid_q <= in_pl;
    end
  end

  assign out_seq  = head_q.seq;
  assign out_tag  = head_q.tag;
  assign out_data = head_q.data;
`ifdef ANON_STRUCT_SKID_PARITY_EN
  assign out_parity = head_q.parity;
`endif

endmodule

// File: tb/tb_anon_struct_skid.sv
// Directed bench for anon_struct_skid: a queue of expected payloads models the two-entry buffer.
// Build with +define+ANON_STRUCT_SKID_PARITY_EN to also check out_parity.
module tb_anon_struct_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_tag;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_tag;
  logic [3:0] out_data;
  logic [2:0] out_seq;
`ifdef ANON_STRUCT_SKID_PARITY_EN
  logic       out_parity;
`endif

  typedef struct packed {
    logic [2:0] seq;
    logic [1:0] tag;
    logic [3:0] data;
    logic       parity;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] model_seq;
  int         checks = 0;
  int         errors = 0;

  anon_struct_skid dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .out_seq   (out_seq)
`ifdef ANON_STRUCT_SKID_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Drives one cycle at the falling edge, checks against the queue model, then advances.
  task automatic apply_stimulus(input logic v, input logic [1:0] t, input logic [3:0] d,
                                input logic ordy);
    exp_t e;
    in_valid  = v;
    in_tag    = t;
    in_data   = d;
    out_ready = ordy;
    #1;
    check_output("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    check_output("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      check_output("out_tag", {30'd0, out_tag}, {30'd0, e.tag});
      check_output("out_data", {28'd0, out_data}, {28'd0, e.data});
      check_output("out_seq", {29'd0, out_seq}, {29'd0, e.seq});
`ifdef ANON_STRUCT_SKID_PARITY_EN
      check_output("out_parity", {31'd0, out_parity}, {31'd0, e.parity});
`endif
    end
    if (in_valid && in_ready) begin
      e = '{seq: model_seq, tag: t, data: d, parity: ^{model_seq, t, d}};
      sb.push_back(e);
      model_seq = model_seq + 3'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("rst_out_data", {28'd0, out_data}, 32'h5);
      check_output("rst_out_seq", {29'd0, out_seq}, 32'd0);
    end
    rst = 1'b0;
    sb.delete();
    model_seq = 3'd0;
    @(posedge clk);
    @(negedge clk);
    check_output("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("post_rst_out_data", {28'd0, out_data}, 32'h5);
    check_output("post_rst_out_tag", {30'd0, out_tag}, 32'd0);
    check_output("post_rst_out_seq", {29'd0, out_seq}, 32'd0);
`ifdef ANON_STRUCT_SKID_PARITY_EN
    check_output("post_rst_parity", {31'd0, out_parity}, 32'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_tag    = 2'd0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    model_seq = 3'd0;

    apply_reset(3);

    // Single beat through an empty buffer; fields persist after the pop.
    apply_stimulus(1'b1, 2'd2, 4'hA, 1'b1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);
    check_output("hold_after_pop_data", {28'd0, out_data}, 32'hA);
    check_output("hold_after_pop_tag", {30'd0, out_tag}, 32'd2);

    // Backpressure fills the skid entry; a beat offered while full is refused.
    apply_reset(1);
    apply_stimulus(1'b1, 2'd1, 4'h1, 1'b0);
    apply_stimulus(1'b1, 2'd1, 4'h2, 1'b0);
    check_output("full_head_data", {28'd0, out_data}, 32'h1);
    apply_stimulus(1'b1, 2'd3, 4'hF, 1'b0);
    check_output("full_head_stable", {28'd0, out_data}, 32'h1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);

    // Ten back-to-back beats exercise the sequence wrap.
    apply_reset(1);
    for (int i = 0; i < 10; i++)
      apply_stimulus(1'b1, 2'(i), 4'(i + 3), 1'b1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);

    // Random mix of valid and backpressure.
    for (int i = 0; i < 40; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
                     1'($urandom_range(0, 1)));
    for (int i = 0; i < 4 && sb.size() != 0; i++)
      apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);
    check_output("drained", sb.size(), 32'd0);

    // Reset while FULL discards both entries and restarts the sequence.
    apply_stimulus(1'b1, 2'd2, 4'h7, 1'b0);
    apply_stimulus(1'b1, 2'd2, 4'h8, 1'b0);
    check_output("pre_rst_full", {31'd0, in_ready}, 32'd0);
    apply_reset(1);
    apply_stimulus(1'b1, 2'd1, 4'h3, 1'b0);
    check_output("new_beat_seq", {29'd0, out_seq}, 32'd0);
`ifdef ANON_STRUCT_SKID_PARITY_EN
    check_output("parity_beat", {31'd0, out_parity}, 32'd1);
`endif
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 4'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
